// File: rtl/bpf_pkg.sv
// Shared BPF VM definitions: snooper FSM states and the packet-memory width derivations.
package bpf_pkg;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_RX,
        ST_DRAIN,
        ST_DONE,
        ST_GAP
    } snoop_state_e;

    // Word width follows from byte depth over word depth of packet memory.
    function automatic int unsigned data_width(input int unsigned byte_addr_width,
                                               input int unsigned word_addr_width);
        return 32'd1 << (3 + byte_addr_width - word_addr_width);
    endfunction

    function automatic int unsigned plen_width(input int unsigned byte_addr_width);
        return byte_addr_width + 1;
    endfunction

endpackage

// File: rtl/axis_packet_snooper_if.sv
// AXI4-Stream beat bundle feeding the packet snooper.
interface axis_packet_snooper_if
    import bpf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = data_width(12, 9)
) ();

    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);

endinterface

// File: rtl/keep_popcount.sv
// Combinational count of set byte enables in a tkeep vector.
module keep_popcount #(
    parameter int unsigned KEEP_WIDTH = 8,
    localparam int unsigned CNT_WIDTH = $clog2(KEEP_WIDTH) + 1
) (
    input  logic [KEEP_WIDTH-1:0] keep,
    output logic [CNT_WIDTH-1:0]  count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            count = count + CNT_WIDTH'(keep[i]);
        end
    end

endmodule

// File: rtl/axis_packet_snooper.sv
// AXI4-Stream ingress into packet memory: one packet per buffer, done pulse plus byte length.
// Optional SNOOPER_DROP_EN: discard and count packets that arrive while no buffer is free.
module axis_packet_snooper
    import bpf_pkg::*;
#(
    parameter int unsigned PACKET_BYTE_ADDR_WIDTH = 12,
    parameter int unsigned SNOOP_FWD_ADDR_WIDTH   = 9,
    localparam int unsigned DATA_WIDTH = data_width(PACKET_BYTE_ADDR_WIDTH, SNOOP_FWD_ADDR_WIDTH),
    localparam int unsigned PLEN_WIDTH = plen_width(PACKET_BYTE_ADDR_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    axis_packet_snooper_if.slave            s_axis,
    output logic [SNOOP_FWD_ADDR_WIDTH-1:0] snooper_wr_addr,
    output logic [DATA_WIDTH-1:0]           snooper_wr_data,
    output logic                            snooper_wr_en,
    output logic                            snooper_done,
    input  logic                            ready_for_snooper,
    output logic [PLEN_WIDTH-1:0]           snooper_byte_len,
    output logic [15:0]                     drop_count
);

    localparam int unsigned KCNT_WIDTH = $clog2(DATA_WIDTH / 8) + 1;
    localparam logic [PLEN_WIDTH-1:0] LEN_CAP = {1'b1, {PACKET_BYTE_ADDR_WIDTH{1'b0}}};

    logic [1:0] rst_sync;
    logic       rst_core;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= '0;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_core = rst_sync[1];

    snoop_state_e                    state;
    snoop_state_e                    beat_next;
    logic                            tready;
    logic [SNOOP_FWD_ADDR_WIDTH-1:0] word_cnt;
    logic [PLEN_WIDTH-1:0]           byte_acc;
    logic [PLEN_WIDTH-1:0]           acc_next;
    logic [PLEN_WIDTH:0]             acc_sum;
    logic [KCNT_WIDTH-1:0]           keep_bytes;
    logic                            hs;
    logic                            take_first;
    logic                            write_beat;

    keep_popcount #(.KEEP_WIDTH(DATA_WIDTH / 8)) u_keep_popcount (
        .keep  (s_axis.tkeep),
        .count (keep_bytes)
    );

    assign s_axis.tready = tready;
    assign hs            = s_axis.tvalid & tready;
    assign acc_sum       = {1'b0, byte_acc} + (PLEN_WIDTH + 1)'(keep_bytes);
    assign acc_next      = (acc_sum > {1'b0, LEN_CAP}) ? LEN_CAP : acc_sum[PLEN_WIDTH-1:0];
    assign beat_next     = s_axis.tlast ? ST_DONE : ((word_cnt == '1) ? ST_DRAIN : ST_RX);

`ifdef SNOOPER_DROP_EN
    logic        dropping;
    logic [15:0] drop_q;

    // With dropping enabled a first beat can be taken straight out of WAIT.
    assign take_first = (state == ST_WAIT) && !dropping && ready_for_snooper;
    assign drop_count = drop_q;
`else
    assign take_first = 1'b0;
    assign drop_count = '0;
`endif

    assign write_beat = hs && ((state == ST_RX) || take_first);

    always_ff @(posedge clk or negedge rst_core) begin
        if (!rst_core) begin
            state            <= ST_WAIT;
            tready           <= 1'b0;
            word_cnt         <= '0;
            byte_acc         <= '0;
            snooper_wr_addr  <= '0;
            snooper_wr_data  <= '0;
            snooper_wr_en    <= 1'b0;
            snooper_done     <= 1'b0;
            snooper_byte_len <= '0;
`ifdef SNOOPER_DROP_EN
            dropping         <= 1'b0;
            drop_q           <= '0;
`endif
        end else begin
            snooper_wr_en <= 1'b0;
            snooper_done  <= 1'b0;

            if (write_beat) begin
                snooper_wr_en   <= 1'b1;
                snooper_wr_addr <= word_cnt;
                snooper_wr_data <= s_axis.tdata;
                word_cnt        <= word_cnt + SNOOP_FWD_ADDR_WIDTH'(1);
                byte_acc        <= acc_next;
            end

            unique case (state)
                ST_WAIT: begin
`ifdef SNOOPER_DROP_EN
                    tready <= 1'b1;
                    if (dropping || (hs && !ready_for_snooper)) begin
                        if (hs && s_axis.tlast) begin
                            dropping <= 1'b0;
                            if (drop_q != '1) drop_q <= drop_q + 16'd1;
                        end else if (hs) begin
                            dropping <= 1'b1;
                        end
                    end else if (hs) begin
                        state  <= beat_next;
                        tready <= (beat_next != ST_DONE);
                    end else if (ready_for_snooper) begin
                        state <= ST_RX;
                    end
`else
                    if (ready_for_snooper) begin
                        state  <= ST_RX;
                        tready <= 1'b1;
                    end
`endif
                end
                ST_RX: begin
                    if (hs) begin
                        state  <= beat_next;
                        tready <= (beat_next != ST_DONE);
                    end
                end
                ST_DRAIN: begin
                    if (hs && s_axis.tlast) begin
                        state  <= ST_DONE;
                        tready <= 1'b0;
                    end
                end
                ST_DONE: begin
                    snooper_done     <= 1'b1;
                    snooper_byte_len <= byte_acc;
                    word_cnt         <= '0;
                    byte_acc         <= '0;
                    state            <= ST_GAP;
                end
                ST_GAP: begin
                    state <= ST_WAIT;
`ifdef SNOOPER_DROP_EN
                    tready <= 1'b1;
`else
                    tready <= 1'b0;
`endif
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_packet_snooper.sv
// Randomized and directed bench for axis_packet_snooper against a packet-level reference model.
module tb_axis_packet_snooper;

    localparam int DW    = 64;
    localparam int WORDS = 512;
    localparam int CAP   = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ready_for_snooper = 1'b0;
    logic [8:0]  snooper_wr_addr;
    logic [63:0] snooper_wr_data;
    logic        snooper_wr_en;
    logic        snooper_done;
    logic [12:0] snooper_byte_len;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    axis_packet_snooper_if #(.DATA_WIDTH(DW)) axis ();

    axis_packet_snooper #(
        .PACKET_BYTE_ADDR_WIDTH(12),
        .SNOOP_FWD_ADDR_WIDTH  (9)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis           (axis),
        .snooper_wr_addr  (snooper_wr_addr),
        .snooper_wr_data  (snooper_wr_data),
        .snooper_wr_en    (snooper_wr_en),
        .snooper_done     (snooper_done),
        .ready_for_snooper(ready_for_snooper),
        .snooper_byte_len (snooper_byte_len),
        .drop_count       (drop_count)
    );

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    int n_dones = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: packet-level bookkeeping driven by observed handshakes.
    bit          m_in_pkt = 0, m_dropping = 0;
    int          m_word = 0, m_bytes = 0, m_drops = 0, exp_len = 0;
    bit          e_wr_en = 0, e_done = 0, e_done_d1 = 0;
    logic [8:0]  e_addr = '0;
    logic [63:0] e_data = '0;
    int          e_len = 0, e_len_d1 = 0;

    always @(negedge clk) begin
        if (!rst) begin
            m_in_pkt = 0; m_drops = 0; exp_len = 0;
            e_wr_en = 0; e_done = 0; e_done_d1 = 0;
            check("reset_outputs",
                  {snooper_wr_en, snooper_done, axis.tready, |snooper_wr_addr,
                   |snooper_wr_data, |snooper_byte_len, |drop_count}, 64'd0);
        end else begin
            if (e_done) exp_len = e_len;
            check("wr_en", snooper_wr_en, e_wr_en);
            if (e_wr_en) begin
                check("wr_addr", snooper_wr_addr, e_addr);
                check("wr_data", snooper_wr_data, e_data);
            end
            check("done", snooper_done, e_done);
            check("byte_len", snooper_byte_len, exp_len);
            check("drop_count", drop_count, m_drops);
            n_writes += snooper_wr_en;
            n_dones  += snooper_done;

            e_done = e_done_d1; e_len = e_len_d1; e_done_d1 = 0; e_wr_en = 0;
            if (axis.tvalid && axis.tready) begin
                if (!m_in_pkt) begin
                    m_in_pkt = 1; m_word = 0; m_bytes = 0;
`ifdef SNOOPER_DROP_EN
                    m_dropping = !ready_for_snooper;
`else
                    m_dropping = 0;
`endif
                end
                if (!m_dropping && m_word < WORDS) begin
                    e_wr_en = 1;
                    e_addr  = 9'(m_word);
                    e_data  = axis.tdata;
                    m_bytes += $countones(axis.tkeep);
                end
                m_word++;
                if (axis.tlast) begin
                    m_in_pkt = 0;
                    if (m_dropping) begin
                        if (m_drops < 65535) m_drops++;
                    end else begin
                        e_done_d1 = 1;
                        e_len_d1  = (m_bytes > CAP) ? CAP : m_bytes;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [7:0] keep_of(input int n);
        logic [8:0] t;
        t = (9'd1 << n) - 9'd1;
        return t[7:0];
    endfunction

    task automatic send_beat(input logic [63:0] data, input logic [7:0] keep, input bit last);
        int waited = 0;
        axis.tdata = data; axis.tkeep = keep; axis.tlast = last; axis.tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (axis.tready) break;
            waited++;
            if (waited > 3000) begin
                checks++; errors++;
                $display("FAIL beat_accept: tready still 0 after %0d cycles, required 1", waited);
                break;
            end
        end
        @(posedge clk); #1;
        axis.tvalid = 1'b0;
    endtask

    // mode 0: all bytes, 1: random contiguous keep, 2: FF,FF then 0F
    task automatic send_packet(input int len, input int mode, input bit gaps);
        logic [7:0] k;
        for (int i = 0; i < len; i++) begin
            if (gaps) step($urandom_range(0, 2));
            case (mode)
                0:       k = 8'hFF;
                1:       k = keep_of($urandom_range(0, 8));
                default: k = (i < 2) ? 8'hFF : 8'h0F;
            endcase
            send_beat({$urandom, $urandom}, k, i == len - 1);
        end
    endtask

    task automatic wait_dones(input int target);
        int n = 0;
        while (n_dones < target && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (n_dones < target) begin
            errors++;
            $display("FAIL done_wait: got %0d done pulses, required %0d", n_dones, target);
        end
        @(posedge clk); #1;
    endtask

    int w0, d0;

    initial begin
        axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tdata = '0; axis.tkeep = '0;

        step(3);
        check("rst_tready", axis.tready, 0);
        check("rst_wr_en", snooper_wr_en, 0);
        check("rst_byte_len", snooper_byte_len, 0);
        rst = 1'b1;
        step(3);

        // Backpressure: no buffer available
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
`ifdef SNOOPER_DROP_EN
            check("wait_tready", axis.tready, 1);
`else
            check("wait_tready", axis.tready, 0);
`endif
            @(posedge clk); #1;
        end
`ifdef SNOOPER_DROP_EN
        w0 = n_writes; d0 = n_dones;
        send_packet(4, 0, 0);
        send_packet(4, 0, 0);
        step(4);
        check("drop_count_2", drop_count, 2);
        check("drop_no_writes", n_writes - w0, 0);
        check("drop_no_done", n_dones - d0, 0);
`endif
        ready_for_snooper = 1'b1;
        w0 = n_writes; d0 = n_dones;
        send_packet(4, 1, 0);
        wait_dones(d0 + 1);
        check("bp_writes", n_writes - w0, 4);

        // Three beats FF,FF,0F -> 20 bytes
        w0 = n_writes; d0 = n_dones;
        send_packet(3, 2, 0);
        wait_dones(d0 + 1);
        check("t3_writes", n_writes - w0, 3);
        check("t3_byte_len", snooper_byte_len, 20);

        // Oversize packet drains past the last word
        w0 = n_writes; d0 = n_dones;
        send_packet(600, 0, 0);
        wait_dones(d0 + 1);
        check("t600_writes", n_writes - w0, 512);
        check("t600_dones", n_dones - d0, 1);
        check("t600_byte_len", snooper_byte_len, 4096);

        // tlast exactly on the final addressable word
        w0 = n_writes; d0 = n_dones;
        send_packet(512, 0, 0);
        wait_dones(d0 + 1);
        check("t512_writes", n_writes - w0, 512);
        check("t512_byte_len", snooper_byte_len, 4096);

        // Random traffic
        d0 = n_dones;
        for (int p = 0; p < 25; p++) send_packet($urandom_range(1, 20), 1, 1);
        wait_dones(d0 + 25);

        // Reset in the middle of a packet
        d0 = n_dones;
        for (int i = 0; i < 5; i++) send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_tready", axis.tready, 0);
        check("mid_rst_wr_en", snooper_wr_en, 0);
        check("mid_rst_byte_len", snooper_byte_len, 0);
        check("mid_rst_done", snooper_done, 0);
        step(3);
        rst = 1'b1;
        step(4);
        check("mid_rst_no_done", n_dones - d0, 0);
        w0 = n_writes;
        send_packet(2, 0, 0);
        wait_dones(d0 + 1);
        check("post_rst_writes", n_writes - w0, 2);
        check("post_rst_byte_len", snooper_byte_len, 16);

        step(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
